// File: rtl/wb_registered_intercon.sv
// Registered Wishbone 1:N interconnect: one upstream request is decoded on the upper
// address bits and forwarded to a single downstream target. Every output comes from a flop.
module wb_registered_intercon #(
    parameter int NUM_TARGETS    = 4,
    parameter int ADDR_WIDTH     = 15,
    parameter int SUB_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT        = 255
) (
    input  logic                                    wb_clk_i,
    input  logic                                    wb_rstn_i,
    input  logic                                    clock_enabled_i,
    input  logic                                    wb_cyc_i,
    input  logic                                    wb_stb_i,
    input  logic                                    wb_we_i,
    input  logic [ADDR_WIDTH-1:0]                   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]                   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0]                 wb_sel_i,
    output logic [DATA_WIDTH-1:0]                   wb_dat_o,
    output logic                                    wb_ack_o,
    output logic                                    wb_err_o,
    output logic                                    wb_rty_o,
    output logic [NUM_TARGETS-1:0]                  m_cyc_o,
    output logic [NUM_TARGETS-1:0]                  m_stb_o,
    output logic [NUM_TARGETS-1:0]                  m_we_o,
    output logic [NUM_TARGETS*SUB_ADDR_WIDTH-1:0]   m_adr_o,
    output logic [NUM_TARGETS*DATA_WIDTH-1:0]       m_dat_o,
    output logic [NUM_TARGETS*DATA_WIDTH/8-1:0]     m_sel_o,
    input  logic [NUM_TARGETS*DATA_WIDTH-1:0]       m_dat_i,
    input  logic [NUM_TARGETS-1:0]                  m_ack_i,
    input  logic [NUM_TARGETS-1:0]                  m_err_i,
    output logic [7:0]                              err_cnt_o
);

    localparam int TW = ADDR_WIDTH - SUB_ADDR_WIDTH;
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

    state_t                              state_q, state_d;
    logic [TW-1:0]                       tgt_q, tgt_d;
    logic [SUB_ADDR_WIDTH-1:0]           sub_q, sub_d;
    logic                                we_q, we_d;
    logic [SW-1:0]                       sel_q, sel_d;
    logic [DATA_WIDTH-1:0]               wdat_q, wdat_d;
    logic [CW-1:0]                       cnt_q, cnt_d;
    logic [NUM_TARGETS-1:0]              m_cyc_q, m_cyc_d;
    logic [NUM_TARGETS-1:0]              m_we_q, m_we_d;
    logic [NUM_TARGETS*SUB_ADDR_WIDTH-1:0] m_adr_q, m_adr_d;
    logic [NUM_TARGETS*DATA_WIDTH-1:0]   m_dat_q, m_dat_d;
    logic [NUM_TARGETS*SW-1:0]           m_sel_q, m_sel_d;
    logic                                ack_q, ack_d;
    logic                                err_q, err_d;
    logic [DATA_WIDTH-1:0]               rdat_q, rdat_d;
    logic [7:0]                          err_cnt_q, err_cnt_d;

    logic [TW-1:0]                       req_tgt;
    logic                                req, mapped, tmo;
    logic                                t_ack, t_err;
    logic [DATA_WIDTH-1:0]               t_dat;

    assign req     = wb_cyc_i & wb_stb_i;
    assign req_tgt = wb_adr_i[ADDR_WIDTH-1:SUB_ADDR_WIDTH];
    assign mapped  = {1'b0, req_tgt} < (TW+1)'(NUM_TARGETS);
    assign tmo     = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));

    // Only the latched target's terminations and read data are ever looked at.
    always_comb begin
        t_ack = 1'b0;
        t_err = 1'b0;
        t_dat = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (tgt_q == TW'(i)) begin
                t_ack = m_ack_i[i];
                t_err = m_err_i[i];
                t_dat = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (req) state_d = (!clock_enabled_i || !mapped) ? FINISH : ISSUE;
            ISSUE:  state_d = wb_cyc_i ? WAIT : IDLE;
            WAIT:   if (!wb_cyc_i) state_d = IDLE;
                    else if (t_ack || t_err || tmo) state_d = FINISH;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tgt_d  = tgt_q;
        sub_d  = sub_q;
        we_d   = we_q;
        sel_d  = sel_q;
        wdat_d = wdat_q;
        cnt_d  = '0;
        ack_d  = 1'b0;
        err_d  = 1'b0;
        rdat_d = '0;
        case (state_q)
            IDLE: if (req) begin
                tgt_d  = req_tgt;
                sub_d  = wb_adr_i[SUB_ADDR_WIDTH-1:0];
                we_d   = wb_we_i;
                sel_d  = wb_sel_i;
                wdat_d = wb_we_i ? wb_dat_i : '0;
                // An unmapped address is an error even when the target side is asleep.
                if (!mapped)               err_d = 1'b1;
                else if (!clock_enabled_i) ack_d = 1'b1;
            end
            WAIT: if (wb_cyc_i) begin
                cnt_d = cnt_q + 1'b1;
                if (t_err || t_ack) begin
                    err_d  = t_err;
                    ack_d  = ~t_err;
                    rdat_d = we_q ? '0 : t_dat;
                end else if (tmo) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase

        m_cyc_d = '0;
        m_we_d  = '0;
        m_adr_d = '0;
        m_dat_d = '0;
        m_sel_d = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if ((state_d == ISSUE || state_d == WAIT) && tgt_d == TW'(i)) begin
                m_cyc_d[i] = (state_d == WAIT);
                m_we_d[i]  = we_d;
                m_adr_d[i*SUB_ADDR_WIDTH +: SUB_ADDR_WIDTH] = sub_d;
                m_dat_d[i*DATA_WIDTH +: DATA_WIDTH]         = wdat_d;
                m_sel_d[i*SW +: SW]                         = sel_d;
            end
        end

        err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            tgt_q     <= '0;
            sub_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            wdat_q    <= '0;
            cnt_q     <= '0;
            m_cyc_q   <= '0;
            m_we_q    <= '0;
            m_adr_q   <= '0;
            m_dat_q   <= '0;
            m_sel_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdat_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            tgt_q     <= tgt_d;
            sub_q     <= sub_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            wdat_q    <= wdat_d;
            cnt_q     <= cnt_d;
            m_cyc_q   <= m_cyc_d;
            m_we_q    <= m_we_d;
            m_adr_q   <= m_adr_d;
            m_dat_q   <= m_dat_d;
            m_sel_q   <= m_sel_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdat_q    <= rdat_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign wb_dat_o  = rdat_q;
    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign wb_rty_o  = 1'b0;
    assign m_cyc_o   = m_cyc_q;
    assign m_stb_o   = m_cyc_q;
    assign m_we_o    = m_we_q;
    assign m_adr_o   = m_adr_q;
    assign m_dat_o   = m_dat_q;
    assign m_sel_o   = m_sel_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_wb_registered_intercon.sv
// Bench for wb_registered_intercon: directed table, randomized transactions against a
// rule-level model, and hand sequences for abort, reset, unmapped and saturation.
module tb_wb_registered_intercon;

    localparam int N = 4, AW = 15, SAW = 13, DW = 32, TMO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn, clk_en, cyc, stb, we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat;
    logic [3:0]      sel;
    logic [N*DW-1:0] m_dat_i;
    logic [N-1:0]    m_ack_i, m_err_i;

    logic [DW-1:0]    dat_a;
    logic             ack_a, err_a, rty_a;
    logic [N-1:0]     m_cyc_a, m_stb_a, m_we_a;
    logic [N*SAW-1:0] m_adr_a;
    logic [N*DW-1:0]  m_dat_a;
    logic [N*4-1:0]   m_sel_a;
    logic [7:0]       ecnt_a;

    wb_registered_intercon #(.NUM_TARGETS(N), .ADDR_WIDTH(AW), .SUB_ADDR_WIDTH(SAW),
                             .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut_a (
        .wb_clk_i(clk), .wb_rstn_i(rstn), .clock_enabled_i(clk_en),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_dat_i(dat), .wb_sel_i(sel), .wb_dat_o(dat_a), .wb_ack_o(ack_a),
        .wb_err_o(err_a), .wb_rty_o(rty_a), .m_cyc_o(m_cyc_a), .m_stb_o(m_stb_a),
        .m_we_o(m_we_a), .m_adr_o(m_adr_a), .m_dat_o(m_dat_a), .m_sel_o(m_sel_a),
        .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i), .err_cnt_o(ecnt_a));

    // Three-target instance, used for the unmapped-index and saturation sequences.
    logic            b_cyc, b_stb;
    logic [AW-1:0]   b_adr;
    logic [3*DW-1:0] b_mdat_i = '0;
    logic [2:0]      b_mack_i = '0, b_merr_i = '0;
    logic [DW-1:0]   b_dat;
    logic            b_ack, b_err, b_rty;
    logic [2:0]      b_mcyc, b_mstb, b_mwe;
    logic [3*SAW-1:0] b_madr;
    logic [3*DW-1:0] b_mdat;
    logic [11:0]     b_msel;
    logic [7:0]      b_ecnt;
    logic            b_bad = 1'b0;

    wb_registered_intercon #(.NUM_TARGETS(3), .ADDR_WIDTH(AW), .SUB_ADDR_WIDTH(SAW),
                             .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut_b (
        .wb_clk_i(clk), .wb_rstn_i(rstn), .clock_enabled_i(clk_en),
        .wb_cyc_i(b_cyc), .wb_stb_i(b_stb), .wb_we_i(we), .wb_adr_i(b_adr),
        .wb_dat_i(dat), .wb_sel_i(sel), .wb_dat_o(b_dat), .wb_ack_o(b_ack),
        .wb_err_o(b_err), .wb_rty_o(b_rty), .m_cyc_o(b_mcyc), .m_stb_o(b_mstb),
        .m_we_o(b_mwe), .m_adr_o(b_madr), .m_dat_o(b_mdat), .m_sel_o(b_msel),
        .m_dat_i(b_mdat_i), .m_ack_i(b_mack_i), .m_err_i(b_merr_i), .err_cnt_o(b_ecnt));

    always @(negedge clk) if (b_mcyc != '0 || b_rty || rty_a) b_bad <= 1'b1;

    // resp: 0 = target acks, 1 = target errs, 2 = target silent
    typedef struct {
        logic [AW-1:0] adr; logic we; logic [DW-1:0] wdat; logic [3:0] sel; logic ce;
        int resp; int dly; logic [DW-1:0] rdat;
        logic e_ack; logic e_err; logic [DW-1:0] e_dat; int e_first; int e_len; int e_term;
    } vec_t;

    typedef struct {
        logic ack; logic err; logic [DW-1:0] dat; logic [DW-1:0] dat_after; logic [7:0] ecnt;
        int first; int len; int term; logic bad;
        logic [N*SAW-1:0] madr; logic [N*DW-1:0] mdat; logic [N*4-1:0] msel; logic [N-1:0] mwe;
    } obs_t;

    int pass_cnt = 0, chk_cnt = 0, e_errs = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    function automatic vec_t mk(logic [AW-1:0] a, logic w, logic [DW-1:0] wd, logic [3:0] s,
                                logic ce, int resp, int dly, logic [DW-1:0] rd,
                                logic ea, logic ee, logic [DW-1:0] ed, int ef, int el, int et);
        vec_t v;
        v.adr = a; v.we = w; v.wdat = wd; v.sel = s; v.ce = ce; v.resp = resp; v.dly = dly;
        v.rdat = rd; v.e_ack = ea; v.e_err = ee; v.e_dat = ed;
        v.e_first = ef; v.e_len = el; v.e_term = et;
        return v;
    endfunction

    // Reference: cycles counted from the request's sampling edge (cycle 0).
    function automatic vec_t model(vec_t v);
        vec_t r = v;
        r.e_ack = 0; r.e_err = 0; r.e_dat = '0;
        if (!v.ce) begin
            r.e_ack = 1; r.e_first = 0; r.e_len = 0; r.e_term = 1;
        end else begin
            r.e_first = 2;
            if (v.resp != 2 && v.dly < TMO) begin
                r.e_len = v.dly + 1; r.e_term = r.e_first + v.dly + 1;
                r.e_ack = (v.resp == 0); r.e_err = (v.resp == 1);
                if (v.resp == 0 && !v.we) r.e_dat = v.rdat;
            end else begin
                r.e_len = TMO; r.e_term = r.e_first + TMO; r.e_err = 1;
            end
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v, output obs_t o);
        int tgt = int'(v.adr[AW-1:SAW]);
        bit done = 0;
        o.ack = 0; o.err = 0; o.dat = '0; o.dat_after = '0; o.ecnt = '0;
        o.first = 0; o.len = 0; o.term = 0; o.bad = 0;
        o.madr = '0; o.mdat = '0; o.msel = '0; o.mwe = '0;
        @(negedge clk);
        adr = v.adr; we = v.we; dat = v.wdat; sel = v.sel; clk_en = v.ce; cyc = 1; stb = 1;
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clk);
            m_ack_i = '0; m_err_i = '0;
            for (int k = 0; k < N; k++) m_dat_i[k*DW +: DW] = $urandom();
            if (m_cyc_a != '0) begin
                if (o.first == 0) begin
                    o.first = c; o.madr = m_adr_a; o.mdat = m_dat_a; o.msel = m_sel_a; o.mwe = m_we_a;
                end
                o.len++;
                if (m_stb_a != m_cyc_a || m_cyc_a != (N'(1) << tgt)) o.bad = 1;
                if (v.resp != 2 && c - o.first == v.dly) begin
                    if (v.resp == 0) m_ack_i[tgt] = 1'b1;
                    else             m_err_i[tgt] = 1'b1;
                    m_dat_i[tgt*DW +: DW] = v.rdat;
                end
            end
            if (ack_a || err_a) begin
                o.ack = ack_a; o.err = err_a; o.dat = dat_a; o.term = c; done = 1;
                cyc = 0; stb = 0;
            end
        end
        cyc = 0; stb = 0; m_ack_i = '0; m_err_i = '0;
        @(negedge clk);
        o.dat_after = dat_a; o.ecnt = ecnt_a;
        clk_en = 1;
    endtask

    task automatic check_txn(input string tag, input vec_t v, input obs_t o);
        int tgt = int'(v.adr[AW-1:SAW]);
        logic [N*SAW-1:0] e_adr = '0;
        logic [N*DW-1:0]  e_mdat = '0;
        logic [N*4-1:0]   e_sel = '0;
        logic [N-1:0]     e_we = '0;
        chk({tag, ".ack"},   o.ack, v.e_ack);
        chk({tag, ".err"},   o.err, v.e_err);
        chk({tag, ".term"},  o.term, v.e_term);
        chk({tag, ".first"}, o.first, v.e_first);
        chk({tag, ".len"},   o.len, v.e_len);
        chk({tag, ".idle_dat"}, o.dat_after, 0);
        chk({tag, ".stb1hot"}, o.bad, 0);
        if (v.e_ack) chk({tag, ".dat"}, o.dat, v.e_dat);
        if (v.e_err) e_errs++;
        chk({tag, ".ecnt"}, o.ecnt, (e_errs > 255) ? 255 : e_errs);
        if (v.ce) begin
            e_adr[tgt*SAW +: SAW] = v.adr[SAW-1:0];
            e_mdat[tgt*DW +: DW]  = v.we ? v.wdat : '0;
            e_sel[tgt*4 +: 4]     = v.sel;
            e_we[tgt]             = v.we;
            chk({tag, ".madr"}, o.madr, e_adr);
            chk({tag, ".mdat"}, o.mdat, e_mdat);
            chk({tag, ".msel"}, o.msel, e_sel);
            chk({tag, ".mwe"},  o.mwe, e_we);
        end
    endtask

    initial begin
        vec_t  tbl[6];
        vec_t  v;
        obs_t  o;
        logic  seen, term;
        int    nerr;

        tbl[0] = mk(15'h2004, 0, 32'h0,        4'hF, 1, 0, 0, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 2, 1, 3);
        tbl[1] = mk(15'h6010, 1, 32'h12345678, 4'hF, 1, 0, 2, 32'hA5A5A5A5, 1, 0, 32'h0,        2, 3, 5);
        tbl[2] = mk(15'h4000, 0, 32'h0,        4'h3, 1, 2, 0, 32'h0,        0, 1, 32'h0,        2, 4, 6);
        tbl[3] = mk(15'h2000, 0, 32'h0,        4'hF, 0, 0, 0, 32'h11111111, 1, 0, 32'h0,        0, 0, 1);
        tbl[4] = mk(15'h0abc, 0, 32'h0,        4'h1, 1, 1, 1, 32'h22222222, 0, 1, 32'h0,        2, 2, 4);
        tbl[5] = mk(15'h1ffe, 0, 32'h0,        4'hC, 1, 0, 3, 32'hCAFEF00D, 1, 0, 32'hCAFEF00D, 2, 4, 6);

        rstn = 0; clk_en = 1; cyc = 0; stb = 0; we = 0; adr = '0; dat = '0; sel = '0;
        m_dat_i = '0; m_ack_i = '0; m_err_i = '0; b_cyc = 0; b_stb = 0; b_adr = '0;
        repeat (3) @(negedge clk);
        chk("reset.term",  {ack_a, err_a, rty_a}, 0);
        chk("reset.mcyc",  {m_cyc_a, m_stb_a, m_we_a}, 0);
        chk("reset.slice", {m_adr_a, m_sel_a}, 0);
        chk("reset.mdat",  m_dat_a, 0);
        chk("reset.dat",   dat_a, 0);
        chk("reset.ecnt",  ecnt_a, 0);
        rstn = 1;

        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i], o);
            check_txn($sformatf("tbl%0d", i), tbl[i], o);
            if (i == 0) chk("tbl0.slice1_adr", o.madr[SAW +: SAW], 13'h0004);
            if (i == 1) chk("tbl1.slice3_dat", o.mdat[3*DW +: DW], 32'h12345678);
        end

        for (int i = 0; i < 40; i++) begin
            v.adr  = {2'($urandom_range(0, 3)), 13'($urandom())};
            v.we   = 1'($urandom());
            v.wdat = $urandom();
            v.sel  = 4'($urandom());
            v.ce   = ($urandom_range(0, 7) != 0);
            v.resp = ($urandom_range(0, 5) < 4) ? 0 : int'($urandom_range(1, 2));
            v.dly  = $urandom_range(0, 4);
            v.rdat = $urandom();
            v = model(v);
            run_txn(v, o);
            check_txn($sformatf("rnd%0d", i), v, o);
        end

        // Upstream abort in WAIT, with stray terminations on other targets first.
        @(negedge clk);
        adr = 15'h4008; we = 0; clk_en = 1; cyc = 1; stb = 1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = m_cyc_a[2]; end
        chk("abort.wait_reached", seen, 1);
        m_ack_i = 4'b0001; m_err_i = 4'b0010;
        @(negedge clk);
        chk("stray.cyc_held", m_cyc_a, 4'b0100);
        chk("stray.no_term", {ack_a, err_a}, 0);
        m_ack_i = '0; m_err_i = '0; cyc = 0; stb = 0;
        @(negedge clk);
        chk("abort.cyc_drop", m_cyc_a, 0);
        term = 0;
        repeat (3) begin @(negedge clk); term |= ack_a | err_a; end
        chk("abort.no_term", term, 0);

        // Reset in WAIT clears outputs without waiting for a clock edge.
        adr = 15'h2000; cyc = 1; stb = 1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = m_cyc_a[1]; end
        chk("rst.wait_reached", seen, 1);
        rstn = 0;
        #1;
        chk("rst.mcyc_async", {m_cyc_a, m_stb_a}, 0);
        chk("rst.slices", {m_adr_a, m_sel_a, m_we_a}, 0);
        chk("rst.ecnt", ecnt_a, 0);
        e_errs = 0;
        @(negedge clk);
        rstn = 1; cyc = 0; stb = 0;
        term = 0;
        repeat (3) begin @(negedge clk); term |= ack_a | err_a | (m_cyc_a != '0); end
        chk("rst.no_term", term, 0);

        // Unmapped index on the three-target instance, then drive the counter into saturation.
        @(negedge clk);
        b_adr = 15'h6000; b_cyc = 1; b_stb = 1;
        @(negedge clk);
        chk("unmapped.err", {b_ack, b_err}, 2'b01);
        b_cyc = 0; b_stb = 0;
        @(negedge clk);
        chk("unmapped.ecnt", b_ecnt, 1);
        chk("unmapped.idle_dat", b_dat, 0);
        nerr = 1;
        for (int i = 0; i < 259; i++) begin
            @(negedge clk); b_cyc = 1; b_stb = 1;
            @(negedge clk); nerr += int'(b_err); b_cyc = 0; b_stb = 0;
        end
        @(negedge clk);
        chk("sat.err_pulses", nerr, 260);
        chk("sat.ecnt", b_ecnt, 255);
        chk("b.no_mcyc_no_rty", b_bad, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/wb_registered_intercon.md
WB_REGISTERED_INTERCON -- requirements
Module: wb_registered_intercon

Interface
REQ-001 SHALL have parameter NUM_TARGETS, default 4: number of downstream Wishbone targets, 1..2^(ADDR_WIDTH-SUB_ADDR_WIDTH).
REQ-002 SHALL have parameter ADDR_WIDTH, default 15: upstream address width.
REQ-003 SHALL have parameter SUB_ADDR_WIDTH, default 13: downstream address width; upstream bits [ADDR_WIDTH-1:SUB_ADDR_WIDTH] select the target.
REQ-004 SHALL have parameter DATA_WIDTH, default 32: data width, multiple of 8.
REQ-005 SHALL have parameter TIMEOUT, default 255: maximum downstream wait in cycles; 0 disables the timeout.
REQ-006 SHALL have ports, in order:
- wb_clk_i  in  1  sole clock.
- wb_rstn_i  in  1  reset, asynchronous, active-low.
- clock_enabled_i  in  1  target clock domain alive.
- wb_cyc_i/wb_stb_i/wb_we_i  in  1 each  upstream strobes.
- wb_adr_i  in  ADDR_WIDTH  upstream address.
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_sel_i  in  DATA_WIDTH/8  byte selects.
- wb_dat_o  out  DATA_WIDTH  read data.
- wb_ack_o/wb_err_o/wb_rty_o  out  1 each  terminations; wb_rty_o tied 0.
- m_cyc_o/m_stb_o/m_we_o  out  NUM_TARGETS  per-target strobes.
- m_adr_o  out  NUM_TARGETS*SUB_ADDR_WIDTH  flattened per-target address; target i at slice i.
- m_dat_o  out  NUM_TARGETS*DATA_WIDTH  flattened per-target write data.
- m_sel_o  out  NUM_TARGETS*DATA_WIDTH/8  flattened per-target byte selects.
- m_dat_i  in  NUM_TARGETS*DATA_WIDTH  flattened per-target read data.
- m_ack_i/m_err_i  in  NUM_TARGETS  per-target terminations.
- err_cnt_o  out  8  saturating count of error terminations.

Function
REQ-007 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-008 FSM SHALL have states IDLE, ISSUE, WAIT, FINISH.
REQ-009 IDLE: on wb_cyc_i&wb_stb_i SHALL latch target index, sub-address, we, sel, and wb_dat_i (writes only); then go ISSUE, or FINISH if clock_enabled_i=0 or index>=NUM_TARGETS.
REQ-010 ISSUE: selected target's m_adr/m_we/m_sel/m_dat slices SHALL be valid; next state WAIT with that target's m_cyc_o=m_stb_o=1.
REQ-011 Non-selected targets SHALL have cyc/stb/we=0 and adr/dat/sel slices=0.
REQ-012 WAIT: m_ack_i of the selected target SHALL clear m_cyc/m_stb next cycle, capture m_dat_i (reads; 0 for writes), and go FINISH with ack.
REQ-013 WAIT: m_err_i of the selected target SHALL end the cycle identically but with err; if ack and err are both set, err wins.
REQ-014 m_ack_i/m_err_i from non-selected targets, or outside WAIT, SHALL be ignored.
REQ-015 Timeout: with TIMEOUT>0, if no termination arrives after m_cyc_o has been high for TIMEOUT cycles, SHALL drop m_cyc_o and go FINISH with err.
REQ-016 Upstream abort: wb_cyc_i=0 in ISSUE or WAIT SHALL drop m_cyc_o next cycle, return to IDLE, and issue no termination.
REQ-017 FINISH: exactly one of wb_ack_o/wb_err_o SHALL be high for one cycle, with wb_dat_o valid; next state IDLE. wb_dat_o SHALL be 0 outside FINISH.
REQ-018 clock_enabled_i=0 at request SHALL give wb_ack_o with wb_dat_o=0 and no downstream cycle; unmapped index SHALL give wb_err_o.
REQ-019 Latency: request sampled in IDLE at cycle 0 -> m_cyc_o at cycle 2; downstream ack sampled at cycle k -> wb_ack_o at cycle k+1.
REQ-020 err_cnt_o SHALL increment on each wb_err_o pulse and saturate at 255.

Reset
REQ-021 wb_rstn_i=0 SHALL asynchronously force IDLE, all outputs 0, timeout counter 0, err_cnt_o 0; a mid-transaction reset SHALL drop m_cyc_o at once and emit no termination.

Verification
REQ-022 Bench SHALL cover:
- read, adr=0x2004, target 1 acks 1 cycle after m_cyc, dat=0xDEADBEEF -> m_adr_o slice1=0x0004, wb_ack_o at cycle 3, wb_dat_o=0xDEADBEEF.
- write 0x12345678 to adr=0x6010 -> target 3 m_we=1, m_dat=0x12345678; other slices 0; wb_dat_o=0.
- TIMEOUT=4, target never acks -> m_cyc_o high exactly 4 cycles, wb_err_o pulse, err_cnt_o=1.
- clock_enabled_i=0 -> no m_cyc_o, wb_ack_o at cycle 1, dat 0; NUM_TARGETS=3 with adr=0x6000 -> wb_err_o.
- wb_cyc_i dropped in WAIT, plus wb_rstn_i=0 in WAIT -> m_cyc_o clears, no ack/err; stray ack on another target ignored.
